// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, load/store port and memory-side bus of the unified
// memory arbiter so the pipeline, memory and arbiter share one connection.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Pipeline plus memory side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the IF fetch port and the
// MEM load/store port; DM has priority, bounded by a fetch starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               CLK_IN,
    input  logic               GLOBALRESET,
    mem_port_arbiter_if.slave  bus
);

    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam int STV_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              w_grant_if;
    logic              w_grant_dm;
    logic              w_capture;
    logic [STV_W-1:0]  w_starve_next;

    logic [CNT_W-1:0]  r_cnt;
    logic [STV_W-1:0]  r_starve_cnt;
    logic              r_sel_dm;
    logic              r_store;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_ready;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_dm_ready;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_busy;

    // State register
    always_ff @(posedge CLK_IN) begin
        if (GLOBALRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, arbitration and starvation bookkeeping
    always_comb begin
        w_state_next  = r_state;
        w_grant_if    = 1'b0;
        w_grant_dm    = 1'b0;
        w_capture     = 1'b0;
        w_starve_next = r_starve_cnt;

        case (r_state)
            ST_IDLE: begin
                // DM wins a tie unless fetch has already waited STARVE_LIMIT grants
                if (bus.dm_req && (!bus.if_req || (r_starve_cnt != STARVE_MAX))) begin
                    w_grant_dm   = 1'b1;
                    w_state_next = ST_ACCESS;
                end else if (bus.if_req) begin
                    w_grant_if   = 1'b1;
                    w_state_next = ST_ACCESS;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_grant_if) begin
            w_starve_next = {STV_W{1'b0}};
        end else if (w_grant_dm) begin
            if (!bus.if_req) begin
                w_starve_next = {STV_W{1'b0}};
            end else if (r_starve_cnt != STARVE_MAX) begin
                w_starve_next = r_starve_cnt + STV_W'(1);
            end else begin
                w_starve_next = r_starve_cnt;
            end
        end else begin
            w_starve_next = r_starve_cnt;
        end
    end

    // Grant latch, latency counter and starvation counter
    always_ff @(posedge CLK_IN) begin
        if (GLOBALRESET) begin
            r_cnt        <= {CNT_W{1'b0}};
            r_starve_cnt <= {STV_W{1'b0}};
            r_sel_dm     <= 1'b0;
            r_store      <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_next;
            if (w_grant_dm || w_grant_if) begin
                r_cnt    <= LAT_LOAD;
                r_sel_dm <= w_grant_dm;
                r_store  <= w_grant_dm & bus.dm_we;
            end else if ((r_state == ST_ACCESS) && (r_cnt != {CNT_W{1'b0}})) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Memory strobe: the winner's request is presented for exactly the first ACCESS cycle
    always_ff @(posedge CLK_IN) begin
        if (GLOBALRESET) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
        end else if (w_grant_dm) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.dm_we;
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
        end else if (w_grant_if) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= {DATA_W{1'b0}};
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
        end
    end

    // Response capture and single-cycle ready pulses; stores leave dm_rdata untouched
    always_ff @(posedge CLK_IN) begin
        if (GLOBALRESET) begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_if_rdata <= {DATA_W{1'b0}};
            r_dm_rdata <= {DATA_W{1'b0}};
        end else if (w_capture && r_sel_dm) begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b1;
            if (!r_store) begin
                r_dm_rdata <= bus.mem_rdata;
            end else begin
                r_dm_rdata <= r_dm_rdata;
            end
        end else if (w_capture) begin
            r_if_ready <= 1'b1;
            r_dm_ready <= 1'b0;
            r_if_rdata <= bus.mem_rdata;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
        end
    end

    // Busy mirrors the registered state so it is glitch-free
    always_ff @(posedge CLK_IN) begin
        if (GLOBALRESET) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_ready  = r_dm_ready;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, cycle-indexed
// expectations; a second instance runs with MEM_LAT=1.
module tb_mem_port_arbiter;

    logic CLK_IN;
    logic GLOBALRESET;
    int   tot;
    int   bad;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_LIMIT(4)) dut (
        .CLK_IN      (CLK_IN),
        .GLOBALRESET (GLOBALRESET),
        .bus         (bus.slave)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(4)) dut_lat1 (
        .CLK_IN      (CLK_IN),
        .GLOBALRESET (GLOBALRESET),
        .bus         (bus2.slave)
    );

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    task automatic next_cycle();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req    = 1'b0;  bus.if_addr  = 32'h0;
        bus.dm_req    = 1'b0;  bus.dm_we    = 1'b0;
        bus.dm_addr   = 32'h0; bus.dm_wdata = 32'h0;
        bus.mem_rdata = 32'h0;
        bus2.if_req   = 1'b0;  bus2.if_addr = 32'h0;
        bus2.dm_req   = 1'b0;  bus2.dm_we   = 1'b0;
        bus2.dm_addr  = 32'h0; bus2.dm_wdata = 32'h0;
        bus2.mem_rdata = 32'h0;
    endtask

    // Leaves the bench at the start of cycle 0 with both arbiters idle
    task automatic do_reset();
        clear_inputs();
        GLOBALRESET = 1'b1;
        next_cycle();
        next_cycle();
        GLOBALRESET = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0]  got;
        logic [31:0] dsum;
        do_reset();
        @(negedge CLK_IN);
        got  = {bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready, bus.busy};
        dsum = bus.mem_addr | bus.mem_wdata | bus.if_rdata | bus.dm_rdata;
        tot++;
        if (got !== 5'b00000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", got);
        end
        tot++;
        if (dsum !== 32'h0) begin
            bad++; $display("FAIL reset_data got=%h want=00000000", dsum);
        end
        got = {bus2.mem_en, bus2.mem_we, bus2.if_ready, bus2.dm_ready, bus2.busy};
        tot++;
        if (got !== 5'b00000) begin
            bad++; $display("FAIL reset_ctrl_lat1 got=%b want=00000", got);
        end
        next_cycle();
    endtask

    task automatic test_if_only();
        logic [3:0] got, exp;
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            bus.if_req    = (c <= 4);
            bus.if_addr   = 32'h40;
            bus.mem_rdata = (c == 3) ? 32'h2002000A : (32'hBAD00000 + 32'(c));
            @(negedge CLK_IN);
            got = {bus.mem_en, bus.if_ready, bus.dm_ready, bus.busy};
            exp = {(c == 1), (c == 4), 1'b0, (c >= 1 && c <= 4)};
            tot++;
            if (got !== exp) begin
                bad++; $display("FAIL if_only_ctrl c=%0d got=%b want=%b", c, got, exp);
            end
            if (c == 1) begin
                tot++;
                if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h40}) begin
                    bad++; $display("FAIL if_only_strobe we/addr=%b/%h want=0/00000040", bus.mem_we, bus.mem_addr);
                end
            end
            if (c == 2) begin
                tot++;
                if (bus.mem_addr !== 32'h0) begin
                    bad++; $display("FAIL if_only_addr_idle got=%h want=00000000", bus.mem_addr);
                end
            end
            if (c == 4) begin
                tot++;
                if (bus.if_rdata !== 32'h2002000A) begin
                    bad++; $display("FAIL if_only_rdata got=%h want=2002000a", bus.if_rdata);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_dm_priority_store();
        logic [3:0] got, exp;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            bus.dm_req    = (c <= 4);
            bus.dm_we     = 1'b1;
            bus.dm_addr   = 32'h10;
            bus.dm_wdata  = 32'hDEADBEEF;
            bus.if_req    = (c <= 9);
            bus.if_addr   = 32'h44;
            bus.mem_rdata = (c == 8) ? 32'h12345678 : (32'hBAD10000 + 32'(c));
            @(negedge CLK_IN);
            got = {bus.mem_en, bus.if_ready, bus.dm_ready, bus.busy};
            exp = {(c == 1 || c == 6), (c == 9), (c == 4), ((c >= 1 && c <= 4) || (c >= 6 && c <= 9))};
            tot++;
            if (got !== exp) begin
                bad++; $display("FAIL prio_ctrl c=%0d got=%b want=%b", c, got, exp);
            end
            if (c == 1) begin
                tot++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h10, 32'hDEADBEEF}) begin
                    bad++; $display("FAIL prio_store_strobe got=%b/%h/%h want=1/00000010/deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
            if (c == 4) begin
                tot++;
                if (bus.dm_rdata !== 32'h0) begin
                    bad++; $display("FAIL prio_store_rdata_held got=%h want=00000000", bus.dm_rdata);
                end
            end
            if (c == 6) begin
                tot++;
                if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h44}) begin
                    bad++; $display("FAIL prio_if_strobe got=%b/%h want=0/00000044", bus.mem_we, bus.mem_addr);
                end
            end
            if (c == 9) begin
                tot++;
                if (bus.if_rdata !== 32'h12345678) begin
                    bad++; $display("FAIL prio_if_rdata got=%h want=12345678", bus.if_rdata);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_starvation();
        logic [3:0]  got, exp;
        logic [31:0] exp_addr;
        do_reset();
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h100;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        for (int c = 0; c <= 30; c++) begin
            bus.mem_rdata = 32'hC0DE0000 + 32'(c);
            @(negedge CLK_IN);
            got = {bus.mem_en, bus.if_ready, bus.dm_ready, bus.busy};
            exp = {(c % 5 == 1), (c == 24),
                   (c == 4 || c == 9 || c == 14 || c == 19 || c == 29),
                   (c % 5 != 0)};
            tot++;
            if (got !== exp) begin
                bad++; $display("FAIL starve_ctrl c=%0d got=%b want=%b", c, got, exp);
            end
            if (c % 5 == 1) begin
                exp_addr = (c == 21) ? 32'h200 : 32'h100;
                tot++;
                if (bus.mem_addr !== exp_addr) begin
                    bad++; $display("FAIL starve_grant_addr c=%0d got=%h want=%h", c, bus.mem_addr, exp_addr);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_access();
        logic [3:0]  got, exp;
        logic [31:0] dsum;
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            GLOBALRESET   = (c == 2);
            bus.if_req    = (c <= 2) || (c >= 4 && c <= 8);
            bus.if_addr   = (c <= 2) ? 32'h80 : 32'h84;
            bus.mem_rdata = (c == 7) ? 32'h00000077 : (32'hBAD20000 + 32'(c));
            @(negedge CLK_IN);
            got = {bus.mem_en, bus.if_ready, bus.dm_ready, bus.busy};
            exp = {(c == 1 || c == 5), (c == 8), 1'b0, (c == 1 || c == 2 || (c >= 5 && c <= 8))};
            tot++;
            if (got !== exp) begin
                bad++; $display("FAIL rst_mid_ctrl c=%0d got=%b want=%b", c, got, exp);
            end
            if (c == 3) begin
                dsum = bus.mem_addr | bus.mem_wdata | bus.if_rdata | bus.dm_rdata;
                tot++;
                if ({bus.mem_we, dsum} !== 33'h0) begin
                    bad++; $display("FAIL rst_mid_data we=%b data_or=%h want=0/00000000", bus.mem_we, dsum);
                end
            end
            if (c == 5) begin
                tot++;
                if (bus.mem_addr !== 32'h84) begin
                    bad++; $display("FAIL rst_mid_new_addr got=%h want=00000084", bus.mem_addr);
                end
            end
            if (c == 8) begin
                tot++;
                if (bus.if_rdata !== 32'h77) begin
                    bad++; $display("FAIL rst_mid_rdata got=%h want=00000077", bus.if_rdata);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, exp;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            bus.if_req    = (c <= 4);
            bus.if_addr   = 32'h48;
            bus.dm_req    = (c >= 4 && c <= 9);
            bus.dm_we     = 1'b0;
            bus.dm_addr   = 32'h30;
            bus.mem_rdata = (c == 3) ? 32'h0000CAFE :
                            (c == 8) ? 32'hABCD0001 : (32'hBAD30000 + 32'(c));
            @(negedge CLK_IN);
            got = {bus.mem_en, bus.if_ready, bus.dm_ready, bus.busy};
            exp = {(c == 1 || c == 6), (c == 4), (c == 9), ((c >= 1 && c <= 4) || (c >= 6 && c <= 9))};
            tot++;
            if (got !== exp) begin
                bad++; $display("FAIL b2b_ctrl c=%0d got=%b want=%b", c, got, exp);
            end
            if (c == 6) begin
                tot++;
                if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h30}) begin
                    bad++; $display("FAIL b2b_dm_strobe got=%b/%h want=0/00000030", bus.mem_we, bus.mem_addr);
                end
            end
            if (c == 9) begin
                tot++;
                if ({bus.dm_rdata, bus.if_rdata} !== {32'hABCD0001, 32'h0000CAFE}) begin
                    bad++; $display("FAIL b2b_rdata got=%h/%h want=abcd0001/0000cafe", bus.dm_rdata, bus.if_rdata);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_lat1_load();
        logic [3:0] got, exp;
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            bus2.dm_req    = (c <= 3);
            bus2.dm_we     = 1'b0;
            bus2.dm_addr   = 32'h20;
            bus2.mem_rdata = (c == 2) ? 32'h5 : (32'hBAD40000 + 32'(c));
            @(negedge CLK_IN);
            got = {bus2.mem_en, bus2.if_ready, bus2.dm_ready, bus2.busy};
            exp = {(c == 1), 1'b0, (c == 3), (c >= 1 && c <= 3)};
            tot++;
            if (got !== exp) begin
                bad++; $display("FAIL lat1_ctrl c=%0d got=%b want=%b", c, got, exp);
            end
            if (c == 1) begin
                tot++;
                if (bus2.mem_addr !== 32'h20) begin
                    bad++; $display("FAIL lat1_addr got=%h want=00000020", bus2.mem_addr);
                end
            end
            if (c == 3) begin
                tot++;
                if (bus2.dm_rdata !== 32'h5) begin
                    bad++; $display("FAIL lat1_rdata got=%h want=00000005", bus2.dm_rdata);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        tot = 0;
        bad = 0;
        GLOBALRESET = 1'b1;
        clear_inputs();
        next_cycle();
        test_reset();
        test_if_only();
        test_dm_priority_store();
        test_starvation();
        test_reset_mid_access();
        test_back_to_back();
        test_lat1_load();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
